// File: rtl/pipe_ctrl_pkg.sv
// Shared constants and FSM encoding for the pipeline hazard controller.
package pipe_ctrl_pkg;

    localparam int unsigned NSTAGE_DEF     = 6;
    localparam int unsigned FLUSH_HOLD_DEF = 2;
    localparam int unsigned WDOG_LIMIT_DEF = 1023;
    // Wide enough for the largest supported flush hold (15)
    localparam int unsigned HOLD_W         = 4;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/stall_prio_mask.sv
// Priority stall mask: every stage at or below the highest requester holds,
// and the stage just above it takes a bubble.
module stall_prio_mask
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE = NSTAGE_DEF
) (
    input  logic [NSTAGE-1:0] stall_req,
    output logic [NSTAGE-1:0] stall_c,
    output logic [NSTAGE-1:0] bubble_c
);

    always_comb begin
        stall_c  = '0;
        bubble_c = '0;
        // A stage holds if it or any younger-indexed-above stage requests
        for (int k = 0; k < int'(NSTAGE); k++) begin
            stall_c[k] = |(stall_req >> k);
        end
        for (int k = 1; k < int'(NSTAGE); k++) begin
            bubble_c[k] = stall_c[k-1] & ~stall_c[k];
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller with stall watchdog.
// Optional performance counters are enabled with macro PIPE_HAZARD_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned NSTAGE     = NSTAGE_DEF,
    parameter int unsigned FLUSH_HOLD = FLUSH_HOLD_DEF,
    parameter int unsigned WDOG_LIMIT = WDOG_LIMIT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NSTAGE-1:0] stall_req,
    input  logic              flush_i,
    output logic [NSTAGE-1:0] stall_o,
    output logic [NSTAGE-1:0] bubble_o,
    output logic              flush_o,
    output logic              wdog_o,
    output logic [1:0]        state_o
`ifdef PIPE_HAZARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cyc,
    output logic [31:0]       perf_flush_cnt
`endif
);

    localparam int unsigned WDOG_W = $clog2(WDOG_LIMIT + 1);

    pipe_state_e       state;
    pipe_state_e       state_nxt;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_nxt;
    logic [WDOG_W-1:0] wdog_cnt;
    logic [WDOG_W-1:0] wdog_nxt;
    logic [NSTAGE-1:0] mask_c;
    logic [NSTAGE-1:0] bub_c;
    logic              flush_c;
    logic              stall_any;

    stall_prio_mask #(
        .NSTAGE(NSTAGE)
    ) u_mask (
        .stall_req(stall_req),
        .stall_c  (mask_c),
        .bubble_c (bub_c)
    );

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_RUN;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and flush hold counter; a flush request always wins
    always_comb begin
        state_nxt = state;
        hold_nxt  = hold_cnt;
        case (state)
            ST_RUN, ST_STALL: begin
                state_nxt = (stall_req != '0) ? ST_STALL : ST_RUN;
            end
            ST_FLUSH: begin
                if (hold_cnt == '0) begin
                    state_nxt = ST_RUN;
                end else begin
                    hold_nxt = hold_cnt - HOLD_W'(1);
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
        if (flush_i) begin
            state_nxt = ST_FLUSH;
            hold_nxt  = HOLD_W'(FLUSH_HOLD - 1);
        end
    end

    // Outputs: flush masks stall/bubble, reset masks everything
    always_comb begin
        flush_c  = 1'b0;
        stall_o  = '0;
        bubble_o = '0;
        state_o  = state;
        if (!rst) begin
            flush_c = flush_i | (state == ST_FLUSH);
            if (!flush_c) begin
                stall_o  = mask_c;
                bubble_o = bub_c;
            end
        end
        flush_o = flush_c;
    end

    assign stall_any = |stall_o;

    // Saturating count of consecutive stall cycles
    always_comb begin
        wdog_nxt = '0;
        if (stall_any) begin
            wdog_nxt = (wdog_cnt == WDOG_W'(WDOG_LIMIT)) ? wdog_cnt : wdog_cnt + WDOG_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
            wdog_cnt <= '0;
            wdog_o   <= 1'b0;
        end else begin
            hold_cnt <= hold_nxt;
            wdog_cnt <= wdog_nxt;
            wdog_o   <= wdog_o | (wdog_nxt == WDOG_W'(WDOG_LIMIT));
        end
    end

`ifdef PIPE_HAZARD_PERF_EN
    // Flush events count only entries into FLUSH, not re-triggers inside it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cyc <= '0;
            perf_flush_cnt <= '0;
        end else begin
            if (stall_any) begin
                perf_stall_cyc <= perf_stall_cyc + 32'd1;
            end
            if (flush_i && (state == ST_RUN || state == ST_STALL)) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: vector table plus flush, watchdog
// and reset sequences.
module tb_pipe_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic [5:0] stall_req;
    logic       flush_i;
    logic [5:0] stall_o;
    logic [5:0] bubble_o;
    logic       flush_o;
    logic       wdog_o;
    logic [1:0] state_o;
`ifdef PIPE_HAZARD_PERF_EN
    logic [31:0] perf_stall_cyc;
    logic [31:0] perf_flush_cnt;
`endif

    int total = 0;
    int bad   = 0;

    localparam logic [1:0] RUN = 2'd0, STL = 2'd1, FLS = 2'd2;

    typedef struct {
        logic [5:0] req;
        logic       fl;
        logic [5:0] e_stall;
        logic [5:0] e_bub;
        logic       e_flush;
        logic [1:0] e_state;
    } vec_t;

    vec_t vecs[15];

    pipe_hazard_ctrl #(
        .NSTAGE    (6),
        .FLUSH_HOLD(2),
        .WDOG_LIMIT(8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .stall_req(stall_req),
        .flush_i  (flush_i),
        .stall_o  (stall_o),
        .bubble_o (bubble_o),
        .flush_o  (flush_o),
        .wdog_o   (wdog_o),
        .state_o  (state_o)
`ifdef PIPE_HAZARD_PERF_EN
        ,
        .perf_stall_cyc(perf_stall_cyc),
        .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic [5:0] es, input logic [5:0] eb,
                           input logic ef, input logic [1:0] est);
        chk({tag, " stall_o"},  32'(stall_o),  32'(es));
        chk({tag, " bubble_o"}, 32'(bubble_o), 32'(eb));
        chk({tag, " flush_o"},  32'(flush_o),  32'(ef));
        chk({tag, " state_o"},  32'(state_o),  32'(est));
    endtask

    // Apply inputs mid-cycle; outputs are sampled 1ns later, far from posedge
    task automatic cyc(input logic [5:0] r, input logic f);
        @(negedge clk);
        stall_req = r;
        flush_i   = f;
        #1;
    endtask

    initial begin
        vecs[0]  = '{6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN};
        vecs[1]  = '{6'b000100, 1'b0, 6'b000111, 6'b001000, 1'b0, RUN};
        vecs[2]  = '{6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0, STL};
        vecs[3]  = '{6'b100101, 1'b0, 6'b111111, 6'b000000, 1'b0, RUN};
        vecs[4]  = '{6'b000001, 1'b0, 6'b000001, 6'b000010, 1'b0, STL};
        vecs[5]  = '{6'b010000, 1'b0, 6'b011111, 6'b100000, 1'b0, STL};
        vecs[6]  = '{6'b100000, 1'b0, 6'b111111, 6'b000000, 1'b0, STL};
        vecs[7]  = '{6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0, STL};
        vecs[8]  = '{6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN};
        vecs[9]  = '{6'b000011, 1'b1, 6'b000000, 6'b000000, 1'b1, RUN};
        vecs[10] = '{6'b000011, 1'b0, 6'b000000, 6'b000000, 1'b1, FLS};
        vecs[11] = '{6'b000011, 1'b0, 6'b000000, 6'b000000, 1'b1, FLS};
        vecs[12] = '{6'b000011, 1'b0, 6'b000011, 6'b000100, 1'b0, RUN};
        vecs[13] = '{6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0, STL};
        vecs[14] = '{6'b000000, 1'b0, 6'b000000, 6'b000000, 1'b0, RUN};

        // Reset with hostile inputs: everything must read idle
        rst       = 1'b1;
        stall_req = 6'b111111;
        flush_i   = 1'b1;
        @(negedge clk);
        #1;
        chk_out("reset", 6'b0, 6'b0, 1'b0, RUN);
        chk("reset wdog_o", 32'(wdog_o), 32'd0);
        @(negedge clk);
        stall_req = '0;
        flush_i   = 1'b0;
        rst       = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].req, vecs[i].fl);
            chk_out($sformatf("vec%0d", i), vecs[i].e_stall, vecs[i].e_bub,
                    vecs[i].e_flush, vecs[i].e_state);
        end

        // Single flush pulse with a held stall request
        cyc(6'b001000, 1'b1); chk_out("f1 c0", 6'b0, 6'b0, 1'b1, RUN);
        cyc(6'b001000, 1'b0); chk_out("f1 c1", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b001000, 1'b0); chk_out("f1 c2", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b001000, 1'b0); chk_out("f1 c3", 6'b001111, 6'b010000, 1'b0, RUN);
        cyc(6'b000000, 1'b0); chk_out("f1 c4", 6'b0, 6'b0, 1'b0, STL);
        cyc(6'b000000, 1'b0); chk_out("f1 c5", 6'b0, 6'b0, 1'b0, RUN);

        // Second pulse inside FLUSH reloads the hold counter
        cyc(6'b0, 1'b1); chk_out("f2 c0", 6'b0, 6'b0, 1'b1, RUN);
        cyc(6'b0, 1'b0); chk_out("f2 c1", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b0, 1'b1); chk_out("f2 c2", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b0, 1'b0); chk_out("f2 c3", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b0, 1'b0); chk_out("f2 c4", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b0, 1'b0); chk_out("f2 c5", 6'b0, 6'b0, 1'b0, RUN);

        // Watchdog: 8 consecutive stall cycles trip the sticky flag
        for (int c = 0; c < 8; c++) begin
            cyc(6'b000001, 1'b0);
            chk($sformatf("wd c%0d wdog_o", c), 32'(wdog_o), 32'd0);
            chk($sformatf("wd c%0d state_o", c), 32'(state_o), (c == 0) ? 32'(RUN) : 32'(STL));
        end
        cyc(6'b0, 1'b0);
        chk("wd c8 wdog_o", 32'(wdog_o), 32'd1);
        cyc(6'b0, 1'b0);
        chk("wd c9 wdog_o", 32'(wdog_o), 32'd1);
        chk("wd c9 state_o", 32'(state_o), 32'(RUN));

        // Reset asserted in the middle of a flush
        cyc(6'b001000, 1'b1); chk_out("rf c0", 6'b0, 6'b0, 1'b1, RUN);
        cyc(6'b001000, 1'b1); chk_out("rf c1", 6'b0, 6'b0, 1'b1, FLS);
        chk("rf c1 wdog_o", 32'(wdog_o), 32'd1);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall_cyc pre", perf_stall_cyc, 32'd15);
        chk("perf_flush_cnt pre", perf_flush_cnt, 32'd4);
`endif
        #1;
        rst = 1'b1;
        #1;
        chk_out("rf rst", 6'b0, 6'b0, 1'b0, RUN);
        chk("rf rst wdog_o", 32'(wdog_o), 32'd0);
`ifdef PIPE_HAZARD_PERF_EN
        chk("perf_stall_cyc rst", perf_stall_cyc, 32'd0);
        chk("perf_flush_cnt rst", perf_flush_cnt, 32'd0);
`endif
        @(posedge clk);
        #1;
        chk_out("rf rst edge", 6'b0, 6'b0, 1'b0, RUN);

        // Flush present in the first cycle after reset release is honoured
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk_out("rel c0", 6'b0, 6'b0, 1'b1, RUN);
        cyc(6'b0, 1'b0); chk_out("rel c1", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b0, 1'b0); chk_out("rel c2", 6'b0, 6'b0, 1'b1, FLS);
        cyc(6'b0, 1'b0); chk_out("rel c3", 6'b0, 6'b0, 1'b0, RUN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
